// File: rtl/fbuff_tile_writer.sv
// fbuff_tile_writer
//   Write side of the frame buffer port. Packs a raster-order stream of tile colours into
//   frame buffer rows and writes them to sequential addresses 0..FBUFF_DEPTH-1. Tile k of a
//   row lands at bits [k*PXL_WIDTH +: PXL_WIDTH]. Writes go through an external arbiter.
//
// Ports
//   clk_i          pixel clock
//   rstn_i         synchronous active-low reset
//   tile_valid_i   tile_data_i / tile_sof_i valid
//   tile_ready_o   writer can accept a tile this cycle
//   tile_data_i    tile colour
//   tile_sof_i     first tile of a frame
//   fbuff_gnt_i    arbiter grants the fbuff port this cycle
//   fbuff_req_o    packed row pending a write
//   fbuff_en_o     fbuff port enable
//   fbuff_wen_o    fbuff write enable
//   fbuff_addr_o   write row address
//   fbuff_data_o   packed row
//   frame_done_o   1-cycle pulse after the last row of a frame is written
//   sync_err_o     1-cycle pulse after a start-of-frame arrives mid-frame

module fbuff_tile_writer #(
   parameter int unsigned PXL_WIDTH        = 12,
   parameter int unsigned TILE_PER_ROW     = 5,
   parameter int unsigned FBUFF_DATA_WIDTH = 60,
   parameter int unsigned FBUFF_DEPTH      = 3840,
   parameter int unsigned FBUFF_ADDR_WIDTH = 12
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        tile_valid_i,
   output logic                        tile_ready_o,
   input  logic [PXL_WIDTH-1:0]        tile_data_i,
   input  logic                        tile_sof_i,
   input  logic                        fbuff_gnt_i,
   output logic                        fbuff_req_o,
   output logic                        fbuff_en_o,
   output logic                        fbuff_wen_o,
   output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
   output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
   output logic                        frame_done_o,
   output logic                        sync_err_o
);

   localparam int unsigned IdxW = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(TILE_PER_ROW - 1);
   localparam logic [FBUFF_ADDR_WIDTH-1:0] LastAddr = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

   state_e                      state_q;
   logic [IdxW-1:0]             idx_q;
   logic [FBUFF_ADDR_WIDTH-1:0] addr_q;
   logic [FBUFF_DATA_WIDTH-1:0] row_q;
   logic                        frame_done_q;
   logic                        sync_err_q;

   logic in_write;
   logic accept;

   assign in_write     = (state_q == StWrite);
   assign tile_ready_o = ~in_write;
   assign accept       = tile_valid_i & tile_ready_o;

   assign fbuff_req_o  = in_write;
   // Enable follows the grant combinationally so a granted cycle is the write cycle.
   assign fbuff_en_o   = in_write & fbuff_gnt_i;
   assign fbuff_wen_o  = in_write & fbuff_gnt_i;
   assign fbuff_addr_o = in_write ? addr_q : '0;
   assign fbuff_data_o = in_write ? row_q : '0;
   assign frame_done_o = frame_done_q;
   assign sync_err_o   = sync_err_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         addr_q       <= '0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         case (state_q)
            StIdle, StFill: begin
               if (accept) begin
                  if (tile_sof_i) begin
                     // A new frame restarts packing at row 0; any partial row is dropped.
                     if ((state_q == StFill) && ((addr_q != '0) || (idx_q != '0))) begin
                        sync_err_q <= 1'b1;
                     end
                     row_q[PXL_WIDTH-1:0] <= tile_data_i;
                     addr_q               <= '0;
                     if (TILE_PER_ROW == 1) begin
                        idx_q   <= '0;
                        state_q <= StWrite;
                     end else begin
                        idx_q   <= IdxW'(1);
                        state_q <= StFill;
                     end
                  end else if (state_q == StFill) begin
                     row_q[idx_q*PXL_WIDTH +: PXL_WIDTH] <= tile_data_i;
                     if (idx_q == LastIdx) begin
                        idx_q   <= '0;
                        state_q <= StWrite;
                     end else begin
                        idx_q <= idx_q + IdxW'(1);
                     end
                  end
                  // Non-sof tiles in idle are dropped.
               end
            end
            StWrite: begin
               if (fbuff_gnt_i) begin
                  if (addr_q == LastAddr) begin
                     frame_done_q <= 1'b1;
                     addr_q       <= '0;
                     state_q      <= StIdle;
                  end else begin
                     addr_q  <= addr_q + FBUFF_ADDR_WIDTH'(1);
                     state_q <= StFill;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fbuff_tile_writer.sv
// tb_fbuff_tile_writer
//   Directed stimulus for fbuff_tile_writer. Expected row writes are queued when stimulus is
//   issued; a forked monitor pops and compares on every enabled fbuff write.

module tb_fbuff_tile_writer;

   typedef struct packed {
      logic [11:0] addr;
      logic [59:0] data;
   } wr_t;

   logic        clk;
   logic        rstn;
   logic        tile_valid;
   logic        tile_ready;
   logic [11:0] tile_data;
   logic        tile_sof;
   logic        fbuff_gnt;
   logic        fbuff_req;
   logic        fbuff_en;
   logic        fbuff_wen;
   logic [11:0] fbuff_addr;
   logic [59:0] fbuff_data;
   logic        frame_done;
   logic        sync_err;

   int checks;
   int errors;
   int writes_seen;
   int done_cnt;
   int sync_cnt;
   wr_t exp_q[$];

   fbuff_tile_writer dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .tile_valid_i (tile_valid),
      .tile_ready_o (tile_ready),
      .tile_data_i  (tile_data),
      .tile_sof_i   (tile_sof),
      .fbuff_gnt_i  (fbuff_gnt),
      .fbuff_req_o  (fbuff_req),
      .fbuff_en_o   (fbuff_en),
      .fbuff_wen_o  (fbuff_wen),
      .fbuff_addr_o (fbuff_addr),
      .fbuff_data_o (fbuff_data),
      .frame_done_o (frame_done),
      .sync_err_o   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [11:0] a, input logic [59:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic monitor();
      wr_t w;
      bit  prev_last;
      prev_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (frame_done) begin
               done_cnt++;
               chk("frame_done_after_last_write", 64'(prev_last), 64'd1);
            end
            if (sync_err) sync_cnt++;
            prev_last = 1'b0;
            if (fbuff_en || fbuff_wen) begin
               chk("en_eq_wen", 64'(fbuff_en), 64'(fbuff_wen));
               chk("en_only_with_req", 64'(fbuff_req), 64'd1);
               writes_seen++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_write_addr", 64'(fbuff_addr), 64'hFFFF_FFFF);
               end else begin
                  w = exp_q.pop_front();
                  chk("write_addr", 64'(fbuff_addr), 64'(w.addr));
                  chk("write_data", 64'(fbuff_data), 64'(w.data));
               end
               prev_last = (fbuff_addr == 12'd3839);
            end
         end
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tile_valid = 1'b0;
      tile_sof   = 1'b0;
      tile_data  = '0;
      rstn       = 1'b0;
      wait_cycles(2);
      rstn = 1'b1;
   endtask

   // Presents one tile and holds it until accepted (bounded).
   task automatic send_tile(input logic [11:0] d, input logic sof);
      bit acc;
      int n;
      tile_valid = 1'b1;
      tile_data  = d;
      tile_sof   = sof;
      acc        = 1'b0;
      n          = 0;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = tile_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_tile_timeout", 64'd0, 64'd1);
      tile_valid = 1'b0;
      tile_sof   = 1'b0;
   endtask

   initial begin
      logic [59:0] row;
      int          w0;
      int          s0;
      checks      = 0;
      errors      = 0;
      writes_seen = 0;
      done_cnt    = 0;
      sync_cnt    = 0;
      fbuff_gnt   = 1'b1;
      fork
         monitor();
      join_none

      // Reset values
      do_reset();
      chk("rst_ready", 64'(tile_ready), 64'd1);
      chk("rst_req", 64'(fbuff_req), 64'd0);
      chk("rst_en", 64'(fbuff_en), 64'd0);
      chk("rst_wen", 64'(fbuff_wen), 64'd0);
      chk("rst_addr", 64'(fbuff_addr), 64'd0);
      chk("rst_data", 64'(fbuff_data), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_sync_err", 64'(sync_err), 64'd0);

      // 1: single row
      push_exp(12'd0, 60'h004_003_002_001_000);
      for (int i = 0; i < 5; i++) send_tile(12'(i), (i == 0));
      wait_cycles(3);
      chk("t1_writes", 64'(writes_seen), 64'd1);

      // 2: full frame
      do_reset();
      w0 = writes_seen;
      s0 = sync_cnt;
      for (int r = 0; r < 3840; r++) begin
         for (int k = 0; k < 5; k++) row[k*12 +: 12] = 12'(r * 5 + k);
         push_exp(12'(r), row);
         for (int k = 0; k < 5; k++) send_tile(12'(r * 5 + k), (r == 0) && (k == 0));
      end
      wait_cycles(5);
      chk("t2_writes", 64'(writes_seen - w0), 64'd3840);
      chk("t2_frame_done_count", 64'(done_cnt), 64'd1);
      chk("t2_no_sync_err", 64'(sync_cnt - s0), 64'd0);
      chk("t2_idle_ready", 64'(tile_ready), 64'd1);
      chk("t2_idle_req", 64'(fbuff_req), 64'd0);

      // 3: grant stall
      do_reset();
      w0 = writes_seen;
      fbuff_gnt = 1'b0;
      push_exp(12'd0, 60'h305_304_303_302_301);
      for (int i = 0; i < 5; i++) send_tile(12'h301 + 12'(i), (i == 0));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t3_stall_ready", 64'(tile_ready), 64'd0);
         chk("t3_stall_req", 64'(fbuff_req), 64'd1);
         chk("t3_stall_en_wen", 64'({fbuff_en, fbuff_wen}), 64'd0);
      end
      @(posedge clk);
      #1;
      fbuff_gnt = 1'b1;
      wait_cycles(5);
      chk("t3_writes", 64'(writes_seen - w0), 64'd1);

      // 4: non-sof tiles in idle are dropped
      do_reset();
      w0 = writes_seen;
      for (int i = 0; i < 3; i++) send_tile(12'hABC, 1'b0);
      push_exp(12'd0, 60'h555_444_333_222_111);
      send_tile(12'h111, 1'b1);
      send_tile(12'h222, 1'b0);
      send_tile(12'h333, 1'b0);
      send_tile(12'h444, 1'b0);
      send_tile(12'h555, 1'b0);
      wait_cycles(3);
      chk("t4_writes", 64'(writes_seen - w0), 64'd1);

      // 5: sof at tile 7 of a frame
      do_reset();
      s0 = sync_cnt;
      push_exp(12'd0, 60'h504_503_502_501_500);
      for (int i = 0; i < 7; i++) send_tile(12'h500 + 12'(i), (i == 0));
      chk("t5_no_err_before", 64'(sync_cnt - s0), 64'd0);
      send_tile(12'h5AA, 1'b1);
      chk("t5_sync_err_pulse", 64'(sync_err), 64'd1);
      push_exp(12'd0, 60'h5B4_5B3_5B2_5B1_5AA);
      for (int i = 1; i <= 4; i++) send_tile(12'h5B0 + 12'(i), 1'b0);
      wait_cycles(3);
      chk("t5_sync_err_count", 64'(sync_cnt - s0), 64'd1);

      // 6: reset while a write is pending
      do_reset();
      w0 = writes_seen;
      fbuff_gnt = 1'b0;
      for (int i = 0; i < 5; i++) send_tile(12'h700 + 12'(i), (i == 0));
      wait_cycles(2);
      chk("t6_pending_req", 64'(fbuff_req), 64'd1);
      rstn = 1'b0;
      wait_cycles(1);
      fbuff_gnt = 1'b1;
      wait_cycles(1);
      rstn = 1'b1;
      chk("t6_post_rst_ready", 64'(tile_ready), 64'd1);
      chk("t6_post_rst_req", 64'(fbuff_req), 64'd0);
      wait_cycles(10);
      chk("t6_no_write", 64'(writes_seen - w0), 64'd0);
      push_exp(12'd0, 60'h605_604_603_602_601);
      for (int i = 0; i < 5; i++) send_tile(12'h601 + 12'(i), (i == 0));
      wait_cycles(3);
      chk("t6_writes", 64'(writes_seen - w0), 64'd1);

      wait_cycles(5);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
